// File: rtl/vram_arbiter.sv
// Arbitrates one single-port synchronous VRAM between display scan-out fetches (absolute priority)
// and a req/ack host write port that fills the cycles the display leaves free.
module vram_arbiter #(
   parameter int DW      = 8,
   parameter int AW      = 17,
   parameter int SCALE   = 1,
   parameter int H_CELLS = 320,
   parameter int V_CELLS = 240
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          pix_tick_i,
   input  logic          video_on_i,
   input  logic [9:0]    pixel_x_i,
   input  logic [9:0]    pixel_y_i,
   input  logic          wr_req_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic [DW-1:0] wr_data_i,
   output logic          wr_ack_o,
   output logic [AW-1:0] mem_addr_o,
   output logic          mem_we_o,
   output logic [DW-1:0] mem_wdata_o,
   input  logic [DW-1:0] mem_rdata_i,
   output logic [DW-1:0] pix_data_o,
   output logic          pix_valid_o,
   output logic          wr_err_o,
   output logic          overrun_o
);

   localparam logic [31:0] N_CELLS = 32'(H_CELLS * V_CELLS);

   typedef enum logic [1:0] {IDLE, DISP_RD, WR} state_e;

   state_e        state_q, state_d;
   logic          tick_q;
   logic          von_q;
   logic [AW-1:0] cell_q;
   logic          rdBlank_q;
   logic          cap_q;
   logic          wr_ack_q;
   logic          mem_we_q;
   logic [AW-1:0] mem_addr_q;
   logic [DW-1:0] mem_wdata_q;
   logic [DW-1:0] pix_data_q;
   logic          pix_valid_q;
   logic          wr_err_q;
   logic          overrun_q;

   logic [AW-1:0] cellAddr;
   logic          wrInRange;

   // Row-major cell index of the replicated pixel; the multiply wraps at AW bits by design.
   assign cellAddr  = AW'(pixel_y_i >> SCALE) * AW'(H_CELLS) + AW'(pixel_x_i >> SCALE);
   assign wrInRange = (32'(wr_addr_i) < N_CELLS);

   // A pending display fetch always wins; a write never follows a write, and yields to a fresh tick.
   always_comb begin
      state_d = IDLE;
      if (tick_q)
         state_d = DISP_RD;
      else if (wr_req_i && !pix_tick_i && (state_q != WR))
         state_d = WR;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         tick_q      <= 1'b0;
         von_q       <= 1'b0;
         cell_q      <= '0;
         rdBlank_q   <= 1'b0;
         cap_q       <= 1'b0;
         wr_ack_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         pix_data_q  <= '0;
         pix_valid_q <= 1'b0;
         wr_err_q    <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= pix_tick_i;
         if (pix_tick_i) begin
            von_q  <= video_on_i;
            cell_q <= cellAddr;
         end
         if (pix_tick_i && (tick_q || (state_q == DISP_RD)))
            overrun_q <= 1'b1;

         wr_ack_q <= 1'b0;
         mem_we_q <= 1'b0;
         case (state_d)
            DISP_RD: begin
               rdBlank_q <= !von_q;
               if (von_q)
                  mem_addr_q <= cell_q;
            end
            WR: begin
               mem_addr_q  <= wr_addr_i;
               mem_wdata_q <= wr_data_i;
               mem_we_q    <= wrInRange;
               wr_ack_q    <= 1'b1;
               if (!wrInRange)
                  wr_err_q <= 1'b1;
            end
            default: begin
            end
         endcase

         // A fetch superseded by a newer tick is dropped rather than shown late.
         cap_q       <= (state_q == DISP_RD) && !tick_q && !pix_tick_i;
         pix_valid_q <= cap_q;
         if (cap_q)
            pix_data_q <= rdBlank_q ? '0 : mem_rdata_i;
      end
   end

   assign wr_ack_o    = wr_ack_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_we_o    = mem_we_q;
   assign mem_wdata_o = mem_wdata_q;
   assign pix_data_o  = pix_data_q;
   assign pix_valid_o = pix_valid_q;
   assign wr_err_o    = wr_err_q;
   assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: a behavioural synchronous VRAM sits on the memory port and
// every expected value below is a hand-computed constant.
module tb_vram_arbiter;

   logic        clk = 1'b0;
   logic        rstN;
   logic        pixTick;
   logic        videoOn;
   logic [9:0]  pixelX;
   logic [9:0]  pixelY;
   logic        wrReq;
   logic [16:0] wrAddr;
   logic [7:0]  wrData;
   logic        wrAck;
   logic [16:0] memAddr;
   logic        memWe;
   logic [7:0]  memWdata;
   logic [7:0]  memRdata;
   logic [7:0]  pixData;
   logic        pixValid;
   logic        wrErr;
   logic        overrun;

   int checkCount = 0;
   int failCount  = 0;

   logic [7:0] vmem [0:131071];

   vram_arbiter dut (
      .clk_i       (clk),
      .rst_ni      (rstN),
      .pix_tick_i  (pixTick),
      .video_on_i  (videoOn),
      .pixel_x_i   (pixelX),
      .pixel_y_i   (pixelY),
      .wr_req_i    (wrReq),
      .wr_addr_i   (wrAddr),
      .wr_data_i   (wrData),
      .wr_ack_o    (wrAck),
      .mem_addr_o  (memAddr),
      .mem_we_o    (memWe),
      .mem_wdata_o (memWdata),
      .mem_rdata_i (memRdata),
      .pix_data_o  (pixData),
      .pix_valid_o (pixValid),
      .wr_err_o    (wrErr),
      .overrun_o   (overrun)
   );

   // 100 MHz system clock.
   always #5 clk = ~clk;

   // Single-port synchronous VRAM with one cycle of read latency.
   always @(posedge clk) begin
      if (memWe)
         vmem[memAddr] <= memWdata;
      memRdata <= vmem[memAddr];
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Advance to just after the next rising edge, where outputs are stable and inputs may change.
   task automatic stepClock(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic applyStimulus(input logic tick, input logic von, input logic [9:0] x, input logic [9:0] y);
      pixTick = tick;
      videoOn = von;
      pixelX  = x;
      pixelY  = y;
   endtask

   initial begin
      for (int i = 0; i < 131072; i++)
         vmem[i] = 8'h00;
      vmem[0]   = 8'h11;
      vmem[321] = 8'h3C;
      memRdata = 8'h00;
      rstN     = 1'b0;
      wrReq    = 1'b0;
      wrAddr   = '0;
      wrData   = '0;
      applyStimulus(1'b0, 1'b0, 10'd0, 10'd0);

      // Reset state and a plain host write.
      stepClock(2);
      rstN = 1'b1;
      stepClock(2);
      checkOutput("rst_wr_ack",    32'(wrAck),    32'h0);
      checkOutput("rst_mem_we",    32'(memWe),    32'h0);
      checkOutput("rst_mem_addr",  32'(memAddr),  32'h0);
      checkOutput("rst_pix_valid", 32'(pixValid), 32'h0);
      checkOutput("rst_pix_data",  32'(pixData),  32'h0);
      checkOutput("rst_wr_err",    32'(wrErr),    32'h0);
      checkOutput("rst_overrun",   32'(overrun),  32'h0);
      wrReq = 1'b1; wrAddr = 17'd5; wrData = 8'hA5;
      stepClock(1);
      checkOutput("wr1_ack",   32'(wrAck),    32'h1);
      checkOutput("wr1_we",    32'(memWe),    32'h1);
      checkOutput("wr1_addr",  32'(memAddr),  32'd5);
      checkOutput("wr1_wdata", 32'(memWdata), 32'hA5);
      wrReq = 1'b0;
      stepClock(1);
      checkOutput("wr1_ack_pulse", 32'(wrAck),   32'h0);
      checkOutput("wr1_we_pulse",  32'(memWe),   32'h0);
      checkOutput("idle_addr_hold", 32'(memAddr), 32'd5);

      // Visible fetch at x=3,y=2 -> cell 1*320+1 = 321.
      stepClock(2);
      applyStimulus(1'b1, 1'b1, 10'd3, 10'd2);
      stepClock(1);
      applyStimulus(1'b0, 1'b0, 10'd0, 10'd0);
      stepClock(1);
      checkOutput("disp_addr", 32'(memAddr), 32'd321);
      checkOutput("disp_we",   32'(memWe),   32'h0);
      stepClock(1);
      checkOutput("disp_valid_early", 32'(pixValid), 32'h0);
      stepClock(1);
      checkOutput("disp_valid", 32'(pixValid), 32'h1);
      checkOutput("disp_data",  32'(pixData),  32'h3C);
      stepClock(1);
      checkOutput("disp_valid_pulse", 32'(pixValid), 32'h0);
      checkOutput("disp_data_hold",   32'(pixData),  32'h3C);

      // Fetch of cell 5 (x=10,y=1) returns the value written by the host.
      stepClock(2);
      applyStimulus(1'b1, 1'b1, 10'd10, 10'd1);
      stepClock(1);
      applyStimulus(1'b0, 1'b0, 10'd0, 10'd0);
      stepClock(3);
      checkOutput("readback_valid", 32'(pixValid), 32'h1);
      checkOutput("readback_data",  32'(pixData),  32'hA5);

      // Blanked tick: no access, zero pixel, pulse still produced.
      stepClock(2);
      applyStimulus(1'b1, 1'b0, 10'd3, 10'd2);
      stepClock(1);
      applyStimulus(1'b0, 1'b0, 10'd0, 10'd0);
      stepClock(1);
      checkOutput("blank_we",   32'(memWe),   32'h0);
      checkOutput("blank_addr", 32'(memAddr), 32'd5);
      stepClock(2);
      checkOutput("blank_valid", 32'(pixValid), 32'h1);
      checkOutput("blank_data",  32'(pixData),  32'h0);

      // Write request coincident with a tick: display read first, ack two edges later.
      stepClock(2);
      applyStimulus(1'b1, 1'b1, 10'd0, 10'd0);
      wrReq = 1'b1; wrAddr = 17'd100; wrData = 8'h77;
      stepClock(1);
      applyStimulus(1'b0, 1'b0, 10'd0, 10'd0);
      checkOutput("col_ack0", 32'(wrAck), 32'h0);
      stepClock(1);
      checkOutput("col_disp_we",   32'(memWe),   32'h0);
      checkOutput("col_disp_ack",  32'(wrAck),   32'h0);
      checkOutput("col_disp_addr", 32'(memAddr), 32'd0);
      stepClock(1);
      checkOutput("col_wr_ack",  32'(wrAck),   32'h1);
      checkOutput("col_wr_we",   32'(memWe),   32'h1);
      checkOutput("col_wr_addr", 32'(memAddr), 32'd100);
      wrReq = 1'b0;
      stepClock(1);
      checkOutput("col_valid", 32'(pixValid), 32'h1);
      checkOutput("col_data",  32'(pixData),  32'h11);
      checkOutput("col_mem100", 32'(vmem[100]), 32'h77);

      // Out-of-range write and back-to-back ticks.
      stepClock(2);
      wrReq = 1'b1; wrAddr = 17'd76800; wrData = 8'hFF;
      stepClock(1);
      checkOutput("oor_ack", 32'(wrAck), 32'h1);
      checkOutput("oor_we",  32'(memWe), 32'h0);
      checkOutput("oor_err", 32'(wrErr), 32'h1);
      wrReq = 1'b0;
      stepClock(3);
      checkOutput("oor_err_sticky", 32'(wrErr), 32'h1);
      applyStimulus(1'b1, 1'b1, 10'd3, 10'd2);
      stepClock(1);
      checkOutput("ovr_before", 32'(overrun), 32'h0);
      stepClock(1);
      applyStimulus(1'b0, 1'b0, 10'd0, 10'd0);
      checkOutput("ovr_set", 32'(overrun), 32'h1);
      stepClock(6);
      checkOutput("ovr_sticky", 32'(overrun), 32'h1);

      // Asynchronous reset in the middle of a write.
      wrReq = 1'b1; wrAddr = 17'd7; wrData = 8'h42;
      stepClock(1);
      checkOutput("rstwr_pre_ack", 32'(wrAck), 32'h1);
      rstN = 1'b0;
      #1;
      checkOutput("rstwr_ack",     32'(wrAck),   32'h0);
      checkOutput("rstwr_we",      32'(memWe),   32'h0);
      checkOutput("rstwr_addr",    32'(memAddr), 32'h0);
      checkOutput("rstwr_err",     32'(wrErr),   32'h0);
      checkOutput("rstwr_overrun", 32'(overrun), 32'h0);
      wrReq = 1'b0;
      #1 rstN = 1'b1;

      // Asynchronous reset in the middle of a display read.
      stepClock(2);
      applyStimulus(1'b1, 1'b1, 10'd3, 10'd2);
      stepClock(1);
      applyStimulus(1'b0, 1'b0, 10'd0, 10'd0);
      stepClock(1);
      checkOutput("rstrd_pre_addr", 32'(memAddr), 32'd321);
      rstN = 1'b0;
      #1;
      checkOutput("rstrd_addr", 32'(memAddr), 32'h0);
      checkOutput("rstrd_data", 32'(pixData), 32'h0);
      #1 rstN = 1'b1;
      stepClock(3);
      checkOutput("rstrd_no_valid", 32'(pixValid), 32'h0);

      // First fetch after reset works normally.
      applyStimulus(1'b1, 1'b1, 10'd3, 10'd2);
      stepClock(1);
      applyStimulus(1'b0, 1'b0, 10'd0, 10'd0);
      stepClock(3);
      checkOutput("post_rst_valid", 32'(pixValid), 32'h1);
      checkOutput("post_rst_data",  32'(pixData),  32'h3C);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
